keystream_block_sequencer: RTL and testbench
============================================

KEYSTREAM_BLOCK_SEQUENCER -- requirements
Module: keystream_block_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have port start, input, 1 bit: one-cycle job request; sampled only in IDLE or ERR.
REQ-004 The block SHALL have port num_blocks, input, 32 bits: number of 64-byte keystream blocks requested; sampled with start.
REQ-005 The block SHALL have port base_ctr, input, 32 bits (word_t): first block-counter value, supplied by the block counter; sampled with start.
REQ-006 The block SHALL have port core_ready, input, 1 bit: ChaCha20 core can accept a block request.
REQ-007 The block SHALL have port core_done, input, 1 bit: one-cycle pulse when the core finishes the outstanding block.
REQ-008 The block SHALL have port core_start, output, 1 bit: block request valid.
REQ-009 The block SHALL have port core_ctr, output, 32 bits (word_t): counter value for the current request.
REQ-010 The block SHALL have port blocksproduced, output, 32 bits: blocks completed in the current job; feeds back to the block counter.
REQ-011 The block SHALL have port busy, output, 1 bit: high in ISSUE and WAIT.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle job-complete pulse.
REQ-013 The block SHALL have port ctr_wrap_err, output, 1 bit: counter-exhaustion flag, high while in ERR.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, ISSUE, WAIT, DONE and ERR; all outputs SHALL be registered.
REQ-015 In IDLE or ERR, when start=1 and num_blocks!=0, the block SHALL, on the next edge: load core_ctr<=base_ctr; load remaining<=num_blocks; clear blocksproduced to 0; clear ctr_wrap_err; enter ISSUE.
REQ-016 In IDLE or ERR, when start=1 and num_blocks==0, the block SHALL clear ctr_wrap_err, assert done for exactly one cycle on the next cycle, and go to or remain in IDLE.
REQ-017 The block SHALL ignore start while busy=1.
REQ-018 In ISSUE the block SHALL hold core_start=1 and core_ctr stable until core_start&core_ready is sampled high; on that edge it SHALL enter WAIT with core_start<=0.
REQ-019 The block SHALL keep at most one request outstanding, and SHALL ignore core_done in any state other than WAIT.
REQ-020 In WAIT, on core_done the block SHALL increment blocksproduced by 1 and decrement remaining by 1, then branch as in REQ-021 to REQ-023.
REQ-021 If remaining was 1 at that core_done, the block SHALL enter DONE.
REQ-022 Otherwise, if core_ctr==32'hFFFFFFFF, the block SHALL enter ERR; the counter SHALL NOT wrap to 0 (nonce/counter reuse is forbidden).
REQ-023 Otherwise the block SHALL set core_ctr<=core_ctr+1 (modulo 2^32 never reached) and return to ISSUE, so core_start re-asserts on the cycle after core_done.
REQ-024 The block SHALL assert done=1 for exactly one cycle while in DONE, then enter IDLE; blocksproduced SHALL hold its final value until the next accepted start.
REQ-025 The block SHALL hold ctr_wrap_err=1 in ERR until a start is accepted or reset occurs; blocksproduced SHALL keep the count completed before the error.
REQ-026 A final block whose counter is 32'hFFFFFFFF SHALL be legal: if remaining was 1, the block SHALL enter DONE, not ERR.
REQ-027 Minimum job latency SHALL be: start edge -> core_start high the next cycle; last core_done edge -> done high the next cycle.

Reset
REQ-028 When rst_n=0 the block SHALL, immediately and asynchronously, enter IDLE and drive core_start=0, core_ctr=0, blocksproduced=0, busy=0, done=0, ctr_wrap_err=0, remaining=0.
REQ-029 When reset is asserted mid-job, the block SHALL abandon the job; any core_done arriving after release SHALL be ignored.
REQ-030 The block SHALL synchronize reset deassertion externally; the first active edge after release SHALL sample start normally.

Verification
REQ-031 Bench SHALL cover normal job: base_ctr=1, num_blocks=3, core_ready=1, core_done 4 cycles after each request -> core_ctr sequence 1,2,3; blocksproduced 0->1->2->3; single done pulse; busy low afterwards.
REQ-032 Bench SHALL cover ready stall: core_ready=0 for 5 cycles -> core_start and core_ctr held stable; no blocksproduced change.
REQ-033 Bench SHALL cover wrap: base_ctr=32'hFFFFFFFE, num_blocks=4 -> requests FFFFFFFE and FFFFFFFF; after second core_done, ERR with ctr_wrap_err=1 and blocksproduced=2; no request with ctr 0; subsequent start clears the error.
REQ-034 Bench SHALL cover boundary: base_ctr=32'hFFFFFFFF, num_blocks=1 -> one request, done pulse, ctr_wrap_err=0.
REQ-035 Bench SHALL cover zero/ignored inputs: num_blocks=0 -> done only, no core_start; start while busy ignored; spurious core_done in ISSUE ignored.
REQ-036 Bench SHALL cover async reset: rst_n low between clock edges in WAIT -> all outputs 0 before the next edge; late core_done has no effect.

Source files
------------

// File: rtl/keystream_block_sequencer_if.sv
// Job/core handshake bundle for the keystream block sequencer.
// master = sequencer side, slave = job requester plus ChaCha20 core side.
interface keystream_block_sequencer_if;
    logic        start;
    logic [31:0] num_blocks;
    logic [31:0] base_ctr;
    logic        core_ready;
    logic        core_done;
    logic        core_start;
    logic [31:0] core_ctr;
    logic [31:0] blocksproduced;
    logic        busy;
    logic        done;
    logic        ctr_wrap_err;

    modport master (
        input  start, num_blocks, base_ctr, core_ready, core_done,
        output core_start, core_ctr, blocksproduced, busy, done, ctr_wrap_err
    );

    modport slave (
        output start, num_blocks, base_ctr, core_ready, core_done,
        input  core_start, core_ctr, blocksproduced, busy, done, ctr_wrap_err
    );
endinterface

// File: rtl/keystream_block_sequencer.sv
// Issues one ChaCha20 block request at a time for a job of num_blocks blocks,
// stepping the block counter and refusing to wrap it past 32'hFFFFFFFF.
module keystream_block_sequencer (
    input  logic                          clk,
    input  logic                          rst_n,
    keystream_block_sequencer_if.master   bus
);
    typedef logic [31:0] word_t;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

    state_t state_q, state_d;
    word_t  core_ctr_q, core_ctr_d;
    word_t  remaining_q, remaining_d;
    word_t  blocks_q, blocks_d;
    logic   core_start_q, core_start_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   err_q, err_d;
    logic   zero_job;

    always_comb begin
        state_d     = state_q;
        core_ctr_d  = core_ctr_q;
        remaining_d = remaining_q;
        blocks_d    = blocks_q;
        err_d       = err_q;
        zero_job    = 1'b0;

        case (state_q)
            IDLE, ERR: begin
                if (bus.start) begin
                    err_d = 1'b0;
                    if (bus.num_blocks != 32'd0) begin
                        core_ctr_d  = bus.base_ctr;
                        remaining_d = bus.num_blocks;
                        blocks_d    = 32'd0;
                        state_d     = ISSUE;
                    end else begin
                        zero_job = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            ISSUE: begin
                if (core_start_q && bus.core_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.core_done) begin
                    blocks_d    = blocks_q + 32'd1;
                    remaining_d = remaining_q - 32'd1;
                    // The last block may legally use counter FFFFFFFF; only a
                    // further block would need the forbidden wrap to 0.
                    if (remaining_q == 32'd1) begin
                        state_d = DONE;
                    end else if (core_ctr_q == 32'hFFFF_FFFF) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        core_ctr_d = core_ctr_q + 32'd1;
                        state_d    = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs derive from the next state so they come straight off flops.
        core_start_d = (state_d == ISSUE);
        busy_d       = (state_d == ISSUE) || (state_d == WAIT);
        done_d       = (state_d == DONE) || zero_job;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            core_ctr_q   <= 32'd0;
            remaining_q  <= 32'd0;
            blocks_q     <= 32'd0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_ctr_q   <= core_ctr_d;
            remaining_q  <= remaining_d;
            blocks_q     <= blocks_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.core_start     = core_start_q;
    assign bus.core_ctr       = core_ctr_q;
    assign bus.blocksproduced = blocks_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.ctr_wrap_err   = err_q;
endmodule

// File: tb/tb_keystream_block_sequencer.sv
// Directed bench for keystream_block_sequencer: normal job, stall, wrap,
// last-counter boundary, zero/ignored inputs and asynchronous reset.
module tb_keystream_block_sequencer;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    keystream_block_sequencer_if bus ();

    keystream_block_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_core_start"}, {31'd0, bus.core_start}, 32'd0);
        chk({tag, "_core_ctr"}, bus.core_ctr, 32'd0);
        chk({tag, "_blocks"}, bus.blocksproduced, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_err"}, {31'd0, bus.ctr_wrap_err}, 32'd0);
    endtask

    task automatic launch(input logic [31:0] base, input logic [31:0] n);
        bus.start      = 1'b1;
        bus.base_ctr   = base;
        bus.num_blocks = n;
        tick();
        bus.start      = 1'b0;
    endtask

    // Serve one request: expect it within a bounded wait, accept it, then
    // return core_done a few cycles later and check the completed count.
    task automatic do_block(input logic [31:0] exp_ctr, input logic [31:0] exp_cnt);
        int n;
        n = 0;
        while (bus.core_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'd0, bus.core_start}, 32'd1);
        chk("req_ctr", bus.core_ctr, exp_ctr);
        tick();
        chk("req_drop", {31'd0, bus.core_start}, 32'd0);
        tick();
        tick();
        tick();
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        chk("blk_cnt", bus.blocksproduced, exp_cnt);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.num_blocks = 32'd0;
        bus.base_ctr   = 32'd0;
        bus.core_ready = 1'b1;
        bus.core_done  = 1'b0;

        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Normal job: counters 1,2,3.
        launch(32'd1, 32'd3);
        chk("job_start", {31'd0, bus.core_start}, 32'd1);
        chk("job_ctr0", bus.core_ctr, 32'd1);
        chk("job_busy", {31'd0, bus.busy}, 32'd1);
        chk("job_cnt0", bus.blocksproduced, 32'd0);
        do_block(32'd1, 32'd1);
        chk("job_reissue", {31'd0, bus.core_start}, 32'd1);
        do_block(32'd2, 32'd2);
        do_block(32'd3, 32'd3);
        chk("job_done", {31'd0, bus.done}, 32'd1);
        chk("job_busy_end", {31'd0, bus.busy}, 32'd0);
        chk("job_nostart", {31'd0, bus.core_start}, 32'd0);
        tick();
        chk("job_done_1cyc", {31'd0, bus.done}, 32'd0);
        chk("job_cnt_hold", bus.blocksproduced, 32'd3);

        // Ready stall with ignored start and spurious core_done in ISSUE.
        bus.core_ready = 1'b0;
        launch(32'd10, 32'd2);
        bus.start      = 1'b1;
        bus.base_ctr   = 32'd99;
        bus.num_blocks = 32'd5;
        bus.core_done  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.start     = 1'b0;
            bus.core_done = 1'b0;
            chk("stall_start", {31'd0, bus.core_start}, 32'd1);
            chk("stall_ctr", bus.core_ctr, 32'd10);
            chk("stall_cnt", bus.blocksproduced, 32'd0);
        end
        bus.core_ready = 1'b1;
        do_block(32'd10, 32'd1);
        do_block(32'd11, 32'd2);
        chk("stall_done", {31'd0, bus.done}, 32'd1);
        tick();

        // Counter exhaustion: FFFFFFFE, FFFFFFFF, then ERR.
        launch(32'hFFFF_FFFE, 32'd4);
        do_block(32'hFFFF_FFFE, 32'd1);
        do_block(32'hFFFF_FFFF, 32'd2);
        chk("wrap_err", {31'd0, bus.ctr_wrap_err}, 32'd1);
        chk("wrap_busy", {31'd0, bus.busy}, 32'd0);
        chk("wrap_done", {31'd0, bus.done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wrap_noreq", {31'd0, bus.core_start}, 32'd0);
            chk("wrap_err_hold", {31'd0, bus.ctr_wrap_err}, 32'd1);
            chk("wrap_cnt_hold", bus.blocksproduced, 32'd2);
        end
        launch(32'd5, 32'd1);
        chk("wrap_clear", {31'd0, bus.ctr_wrap_err}, 32'd0);
        chk("wrap_restart_ctr", bus.core_ctr, 32'd5);
        chk("wrap_restart_cnt", bus.blocksproduced, 32'd0);
        do_block(32'd5, 32'd1);
        chk("wrap_restart_done", {31'd0, bus.done}, 32'd1);
        tick();

        // Single block at the last legal counter value.
        launch(32'hFFFF_FFFF, 32'd1);
        do_block(32'hFFFF_FFFF, 32'd1);
        chk("last_done", {31'd0, bus.done}, 32'd1);
        chk("last_noerr", {31'd0, bus.ctr_wrap_err}, 32'd0);
        tick();
        chk("last_done_1cyc", {31'd0, bus.done}, 32'd0);

        // Zero-block job.
        launch(32'd40, 32'd0);
        chk("zero_done", {31'd0, bus.done}, 32'd1);
        chk("zero_noreq", {31'd0, bus.core_start}, 32'd0);
        chk("zero_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("zero_done_1cyc", {31'd0, bus.done}, 32'd0);
        chk("zero_noreq2", {31'd0, bus.core_start}, 32'd0);

        // Asynchronous reset while waiting for the core.
        launch(32'd7, 32'd2);
        tick();
        chk("arst_in_wait", {31'd0, bus.busy}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        #2;
        rst_n = 1'b1;
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        chk("arst_late_cnt", bus.blocksproduced, 32'd0);
        chk("arst_late_req", {31'd0, bus.core_start}, 32'd0);
        chk("arst_late_busy", {31'd0, bus.busy}, 32'd0);
        launch(32'd20, 32'd1);
        chk("arst_restart", {31'd0, bus.core_start}, 32'd1);
        do_block(32'd20, 32'd1);
        chk("arst_restart_done", {31'd0, bus.done}, 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
